// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and sizing helpers for the two-master memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    function automatic int lat_cnt_w(input int read_lat);
        return (read_lat < 1) ? 1 : $clog2(read_lat + 1);
    endfunction

    function automatic int lock_cnt_w(input int lock_max);
        return (lock_max < 1) ? 1 : $clog2(lock_max + 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundles both masters' req/ack channels and the memory-side signals.
interface mem_bus_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) ();
    logic          m0_req, m1_req;
    logic          m0_we, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_lock, m1_lock;
    logic          m0_ack, m1_ack;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    grant;
    logic          busy;

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_lock, m1_lock, mem_rdata,
        input  m0_ack, m1_ack, m0_rdata, m1_rdata, mem_we, mem_addr,
               mem_wdata, grant, busy
    );

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_lock, m1_lock, mem_rdata,
        output m0_ack, m1_ack, m0_rdata, m1_rdata, mem_we, mem_addr,
               mem_wdata, grant, busy
    );
endinterface

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick with lock override; one-hot result.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    input  logic       lock_owner,
    input  logic       lock_valid,
    output logic [1:0] win
);
    always_comb begin
        win = 2'b00;
        if (lock_valid && req[lock_owner]) begin
            win[lock_owner] = 1'b1;
        end else if (req == 2'b11) begin
            win[rr_ptr] = 1'b1;
        end else begin
            win = req;
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates a single-port memory between two req/ack masters with
// round-robin fairness, bounded ownership lock and configurable read latency.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int READ_LAT = 1,
    parameter int LOCK_MAX = 8
) (
    input  logic             clk,
    input  logic             reset,
    mem_bus_arbiter_if.slave bus
);
    localparam int LAT_W  = lat_cnt_w(READ_LAT);
    localparam int LOCK_W = lock_cnt_w(LOCK_MAX);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              lock_pend_q, lock_pend_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW-1:0]     rdata_q, rdata_d;

    logic [1:0]        req, win;
    logic              owner_lock, resp;
    logic [DW-1:0]     resp_data;

    assign req        = {bus.m1_req, bus.m0_req};
    assign owner_lock = owner_q ? bus.m1_lock : bus.m0_lock;

    rr_arb2 u_rr_arb2 (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .lock_owner (owner_q),
        .lock_valid (lock_pend_q),
        .win        (win)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        lock_pend_d = lock_pend_q;
        lock_cnt_d  = lock_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (win != 2'b00) begin
                    owner_d = win[1];
                    we_d    = win[1] ? bus.m1_we    : bus.m0_we;
                    addr_d  = win[1] ? bus.m1_addr  : bus.m0_addr;
                    wdata_d = win[1] ? bus.m1_wdata : bus.m0_wdata;
                    // A pending lock the owner no longer wants breaks the run.
                    if (!(lock_pend_q && req[owner_q])) lock_cnt_d = '0;
                    lock_pend_d = 1'b0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = RESP;
                end else if (READ_LAT == 0) begin
                    rdata_d = bus.mem_rdata;
                    state_d = RESP;
                end else begin
                    lat_cnt_d = LAT_W'(1);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q == LAT_W'(READ_LAT)) begin
                    rdata_d = bus.mem_rdata;
                    state_d = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            RESP: begin
                if (owner_lock && (lock_cnt_q < LOCK_W'(LOCK_MAX))) begin
                    lock_pend_d = 1'b1;
                    lock_cnt_d  = lock_cnt_q + LOCK_W'(1);
                end else begin
                    lock_cnt_d = '0;
                    rr_ptr_d   = ~owner_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            rr_ptr_q    <= 1'b0;
            lock_pend_q <= 1'b0;
            lock_cnt_q  <= '0;
            lat_cnt_q   <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_pend_q <= lock_pend_d;
            lock_cnt_q  <= lock_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Outputs that read these are gated by state, so they need no reset.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        rdata_q <= rdata_d;
    end

    assign resp          = (state_q == RESP);
    assign resp_data     = we_q ? '0 : rdata_q;
    assign bus.m0_ack    = resp && !owner_q;
    assign bus.m1_ack    = resp && owner_q;
    assign bus.m0_rdata  = (resp && !owner_q) ? resp_data : '0;
    assign bus.m1_rdata  = (resp && owner_q) ? resp_data : '0;
    assign bus.mem_we    = (state_q == ISSUE) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.grant     = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: transaction table plus sequences for round-robin, lock,
// mid-transaction reset and a zero-latency build.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    mem_bus_arbiter_if #(.AW(32), .DW(32)) bus1 ();
    mem_bus_arbiter_if #(.AW(32), .DW(32)) bus0 ();

    mem_bus_arbiter #(.AW(32), .DW(32), .READ_LAT(1), .LOCK_MAX(8)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));
    mem_bus_arbiter #(.AW(32), .DW(32), .READ_LAT(0), .LOCK_MAX(8)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));

    // Synchronous-read memory for the one-cycle-latency instance
    logic [31:0] mem1 [0:255];
    logic [31:0] rd1;
    always @(posedge clk) begin
        if (bus1.mem_we) mem1[bus1.mem_addr[9:2]] <= bus1.mem_wdata;
        rd1 <= mem1[bus1.mem_addr[9:2]];
    end
    assign bus1.mem_rdata = rd1;

    // Combinational-read memory for the zero-latency instance
    logic [31:0] mem0 [0:255];
    assign bus0.mem_rdata = mem0[bus0.mem_addr[9:2]];

    typedef struct {
        int          m;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drv(input int m, input bit req, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input bit lk);
        if (m == 0) begin
            bus1.m0_req = req; bus1.m0_we = we; bus1.m0_addr = a;
            bus1.m0_wdata = d; bus1.m0_lock = lk;
        end else begin
            bus1.m1_req = req; bus1.m1_we = we; bus1.m1_addr = a;
            bus1.m1_wdata = d; bus1.m1_lock = lk;
        end
    endtask

    function automatic logic ack1(input int m);
        return (m == 0) ? bus1.m0_ack : bus1.m1_ack;
    endfunction

    function automatic logic [31:0] rdat1(input int m);
        return (m == 0) ? bus1.m0_rdata : bus1.m1_rdata;
    endfunction

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
    endtask

    // Waits for the next ack on dut1; who=-1 on timeout
    task automatic wait_ack(output int who, output int at);
        who = -1;
        at  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("grant_two_hot", bus1.grant == 2'b11, 0);
            if (bus1.m0_ack || bus1.m1_ack) begin
                who = bus1.m1_ack ? 1 : 0;
                at  = cyc_n;
                break;
            end
        end
    endtask

    task automatic txn(input int idx, input vec_t v);
        int c;
        bit seen;
        string nm;
        nm = $sformatf("v%0d", idx);
        @(negedge clk);
        drv(v.m, 1'b1, v.we, v.addr, v.wdata, 1'b0);
        @(negedge clk);
        chk({nm, ".mem_we"}, bus1.mem_we, v.we);
        chk({nm, ".mem_addr"}, bus1.mem_addr, v.addr);
        chk({nm, ".grant"}, bus1.grant, (v.m == 0) ? 2'b01 : 2'b10);
        if (v.we) chk({nm, ".mem_wdata"}, bus1.mem_wdata, v.wdata);
        c = 1;
        seen = 1'b0;
        while (!seen && c < 12) begin
            @(negedge clk);
            c++;
            seen = ack1(v.m);
        end
        chk({nm, ".ack_at"}, c, v.we ? 2 : 3);
        chk({nm, ".rdata"}, rdat1(v.m), v.we ? 32'h0 : v.exp);
        chk({nm, ".other_ack"}, ack1(1 - v.m), 0);
        chk({nm, ".mem_we_resp"}, bus1.mem_we, 0);
        drv(v.m, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    int who, at, prev, c;
    bit seen;

    initial begin
        tbl[0] = '{0, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1, 1'b1, 32'h204, 32'h12345678, 32'h0};
        tbl[3] = '{0, 1'b0, 32'h204, 32'h0,        32'h12345678};
        tbl[4] = '{0, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF};
        tbl[5] = '{1, 1'b1, 32'h100, 32'hA5A5A5A5, 32'h0};
        tbl[6] = '{0, 1'b0, 32'h100, 32'h0,        32'hA5A5A5A5};
        mem0[8'h20] = 32'hCAFEF00D;

        drv(0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0);
        bus0.m0_req = 0; bus0.m0_we = 0; bus0.m0_addr = 0; bus0.m0_wdata = 0; bus0.m0_lock = 0;
        bus0.m1_req = 0; bus0.m1_we = 0; bus0.m1_addr = 0; bus0.m1_wdata = 0; bus0.m1_lock = 0;

        repeat (3) @(negedge clk);
        chk("rst.busy", bus1.busy, 0);
        chk("rst.grant", bus1.grant, 0);
        chk("rst.acks", {bus1.m0_ack, bus1.m1_ack}, 0);
        chk("rst.mem_we", bus1.mem_we, 0);
        chk("rst.mem_addr", bus1.mem_addr, 0);
        chk("rst.rdata", {bus1.m0_rdata, bus1.m1_rdata}, 0);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) txn(i, tbl[i]);

        // Reset while an M0 read sits in WAIT
        @(negedge clk); drv(0, 1, 0, 32'h100, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("rstw.busy_before", bus1.busy, 1);
        reset = 1'b0;
        #1;
        chk("rstw.busy", bus1.busy, 0);
        chk("rstw.grant", bus1.grant, 0);
        chk("rstw.mem_addr", bus1.mem_addr, 0);
        chk("rstw.mem_we", bus1.mem_we, 0);
        repeat (2) begin
            @(negedge clk);
            chk("rstw.no_ack", bus1.m0_ack, 0);
        end
        reset = 1'b1;
        c = 0;
        seen = 1'b0;
        while (!seen && c < 12) begin
            @(negedge clk);
            c++;
            seen = bus1.m0_ack;
        end
        chk("rstw.ack_at", c, 3);
        chk("rstw.rdata", bus1.m0_rdata, 32'hA5A5A5A5);
        drv(0, 0, 0, 0, 0, 0);

        // Both masters request continuously: strict alternation
        pulse_reset();
        @(negedge clk);
        drv(0, 1, 1, 32'h300, 32'h11111111, 0);
        drv(1, 1, 1, 32'h304, 32'h22222222, 0);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack(who, at);
            chk($sformatf("alt.who%0d", k), who, k % 2);
            if (k > 0) chk($sformatf("alt.gap%0d", k), at - prev, 3);
            prev = at;
        end
        drv(0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("alt.idle", bus1.busy, 0);

        // M1 locks while M0 competes: 9 M1 grants then M0
        pulse_reset();
        @(negedge clk); drv(1, 1, 1, 32'h400, 32'h33333333, 1);
        @(negedge clk); drv(0, 1, 1, 32'h404, 32'h44444444, 0);
        for (int k = 0; k < 10; k++) begin
            wait_ack(who, at);
            chk($sformatf("lock.who%0d", k), who, (k < 9) ? 1 : 0);
        end
        drv(0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("lock.idle", bus1.busy, 0);

        // Zero-latency instance: data captured at end of ISSUE
        @(negedge clk);
        bus0.m0_req = 1; bus0.m0_we = 0; bus0.m0_addr = 32'h80;
        @(negedge clk);
        chk("rl0.grant", bus0.grant, 2'b01);
        chk("rl0.mem_addr", bus0.mem_addr, 32'h80);
        chk("rl0.early_ack", bus0.m0_ack, 0);
        @(posedge clk);
        #1 mem0[8'h20] = 32'h0;
        @(negedge clk);
        chk("rl0.ack", bus0.m0_ack, 1);
        chk("rl0.rdata", bus0.m0_rdata, 32'hCAFEF00D);
        chk("rl0.m1_ack", bus0.m1_ack, 0);
        bus0.m0_req = 0;
        @(negedge clk);
        chk("rl0.ack_once", bus0.m0_ack, 0);
        chk("rl0.busy_idle", bus0.busy, 0);
        @(negedge clk);
        chk("rl0.no_regrant", bus0.busy, 0);
        chk("rl0.grant_idle", bus0.grant, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
